shape_detection_demo: RTL and testbench

Demo-mode shape splitter for the 2D GPU opcode path. It decodes a 96-bit drawing opcode and breaks the shape into primitive endpoint pairs for the line and arc rasterizers, one primitive per clock. It sits between the opcode FIFO and the line/arc drawing units. In demo mode it self-sequences and does not wait on rasterizer handshakes.

---
 rtl/gpu_pkg.sv | 32 +++
 rtl/shape_detection_demo_opcode_decode.sv | 23 ++
 rtl/shape_detection_demo.sv | 101 ++++++++++
 tb/tb_shape_detection_demo.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU opcode-path definitions: shape and phase encodings, opcode field positions and widths.
package gpu_pkg;

    localparam int unsigned LOC_W   = 19;
    localparam int unsigned COLOR_W = 16;

    localparam int unsigned SHAPE_HI = 95;
    localparam int unsigned SHAPE_LO = 92;
    localparam int unsigned COLOR_HI = 91;
    localparam int unsigned COLOR_LO = 76;
    localparam int unsigned LOC1_HI  = 75;
    localparam int unsigned LOC1_LO  = 57;
    localparam int unsigned LOC2_HI  = 56;
    localparam int unsigned LOC2_LO  = 38;
    localparam int unsigned LOC3_HI  = 37;
    localparam int unsigned LOC3_LO  = 19;
    localparam int unsigned FILL_BIT = 18;

    typedef enum logic [3:0] {
        SHAPE_LINE     = 4'd0,
        SHAPE_TRIANGLE = 4'd1,
        SHAPE_CIRCLE   = 4'd2
    } shape_t;

    typedef enum logic [1:0] {
        P0,
        P1,
        P2,
        DONE
    } phase_t;

endpackage

// File: rtl/shape_detection_demo_opcode_decode.sv
// Combinational slicer splitting a 96-bit drawing opcode into its named fields.
module opcode_decode
    import gpu_pkg::*;
(
    input  logic [95:0]        full_opcode,
    output logic [3:0]         shape,
    output logic [COLOR_W-1:0] color,
    output logic [LOC_W-1:0]   loc1,
    output logic [LOC_W-1:0]   loc2,
    output logic [LOC_W-1:0]   loc3,
    output logic               fill
);

    always_comb begin
        shape = full_opcode[SHAPE_HI:SHAPE_LO];
        color = full_opcode[COLOR_HI:COLOR_LO];
        loc1  = full_opcode[LOC1_HI:LOC1_LO];
        loc2  = full_opcode[LOC2_HI:LOC2_LO];
        loc3  = full_opcode[LOC3_HI:LOC3_LO];
        fill  = full_opcode[FILL_BIT];
    end

endmodule

// File: rtl/shape_detection_demo.sv
// Demo-mode shape splitter: walks the current opcode's shape through its primitive phases, one per clock.
module shape_detection_demo
    import gpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [95:0]          full_opcode,
    input  logic                 new_shape,
    input  logic                 line_done,
    input  logic                 arc_done,
    input  logic                 data_ready,
    output logic                 data_sent,
    output logic                 enable,
    output logic [COLOR_W-1:0]   color,
    output logic                 shape_done,
    output logic                 prim_sel,
    output logic                 write,
    output logic                 read,
    output logic [2*LOC_W-1:0]   locations
);

    logic [3:0]       shape;
    logic [LOC_W-1:0] loc1;
    logic [LOC_W-1:0] loc2;
    logic [LOC_W-1:0] loc3;
    phase_t           phase;
    phase_t           phase_next;

    opcode_decode u_decode (
        .full_opcode (full_opcode),
        .shape       (shape),
        .color       (color),
        .loc1        (loc1),
        .loc2        (loc2),
        .loc3        (loc3),
        .fill        ()
    );

    always_ff @(posedge clk) begin
        if (!n_reset) phase <= P0;
        else          phase <= phase_next;
    end

    // Decoding follows the shape currently presented, so a shape change mid-sequence
    // lands on the new shape's rules; phases it does not have fall through to DONE.
    always_comb begin
        phase_next = P0;
        enable     = 1'b0;
        shape_done = 1'b0;
        prim_sel   = 1'b0;
        locations  = '0;
        case (shape)
            SHAPE_LINE, SHAPE_CIRCLE: begin
                case (phase)
                    P0: begin
                        enable     = 1'b1;
                        locations  = {loc1, loc2};
                        prim_sel   = (shape == SHAPE_CIRCLE);
                        phase_next = DONE;
                    end
                    DONE: begin
                        shape_done = 1'b1;
                        phase_next = P0;
                    end
                    default: phase_next = DONE;
                endcase
            end
            SHAPE_TRIANGLE: begin
                case (phase)
                    P0: begin
                        enable     = 1'b1;
                        locations  = {loc1, loc2};
                        phase_next = P1;
                    end
                    P1: begin
                        enable     = 1'b1;
                        locations  = {loc1, loc3};
                        phase_next = P2;
                    end
                    P2: begin
                        enable     = 1'b1;
                        locations  = {loc2, loc3};
                        phase_next = DONE;
                    end
                    default: begin
                        shape_done = 1'b1;
                        phase_next = P0;
                    end
                endcase
            end
            default: phase_next = P0;
        endcase
    end

    always_comb begin
        write     = enable;
        read      = shape_done;
        data_sent = shape_done;
    end

endmodule

// File: tb/tb_shape_detection_demo.sv
// Randomized bench for shape_detection_demo against a per-shape primitive-list reference model.
module tb_shape_detection_demo;

    logic        tb_clk = 1'b0;
    logic        n_reset;
    logic [95:0] full_opcode;
    logic        new_shape, line_done, arc_done, data_ready;
    logic        data_sent, enable, shape_done, prim_sel, write, read;
    logic [15:0] color;
    logic [37:0] locations;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 tb_clk = ~tb_clk;

    shape_detection_demo dut (
        .clk         (tb_clk),
        .n_reset     (n_reset),
        .full_opcode (full_opcode),
        .new_shape   (new_shape),
        .line_done   (line_done),
        .arc_done    (arc_done),
        .data_ready  (data_ready),
        .data_sent   (data_sent),
        .enable      (enable),
        .color       (color),
        .shape_done  (shape_done),
        .prim_sel    (prim_sel),
        .write       (write),
        .read        (read),
        .locations   (locations)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [95:0] make_op(input logic [3:0] sh, input logic [15:0] col,
                                            input logic [18:0] l1, input logic [18:0] l2,
                                            input logic [18:0] l3);
        logic [18:0] junk;
        junk = 19'($urandom);
        return {sh, col, l1, l2, l3, junk};
    endfunction

    task automatic next_cycle();
        @(posedge tb_clk);
        #1;
        new_shape  = 1'($urandom);
        line_done  = 1'($urandom);
        arc_done   = 1'($urandom);
        data_ready = 1'($urandom);
    endtask

    task automatic check_idle(input string tag, input logic [15:0] col, input logic done);
        @(negedge tb_clk);
        check({tag, ".enable"},     64'(enable),     64'd0);
        check({tag, ".write"},      64'(write),      64'd0);
        check({tag, ".locations"},  64'(locations),  64'd0);
        check({tag, ".prim_sel"},   64'(prim_sel),   64'd0);
        check({tag, ".shape_done"}, 64'(shape_done), 64'(done));
        check({tag, ".read"},       64'(read),       64'(done));
        check({tag, ".data_sent"},  64'(data_sent),  64'(done));
        check({tag, ".color"},      64'(color),      64'(col));
    endtask

    // Model: a shape is an ordered list of endpoint pairs followed by one DONE cycle.
    task automatic run_shape(input string tag, input logic [3:0] sh, input logic [15:0] col,
                             input logic [18:0] l1, input logic [18:0] l2, input logic [18:0] l3);
        logic [18:0] pt [1:3];
        int          a [3];
        int          b [3];
        int          n;
        pt[1] = l1; pt[2] = l2; pt[3] = l3;
        a[0] = 1; b[0] = 2;
        a[1] = 1; b[1] = 3;
        a[2] = 2; b[2] = 3;
        n = (sh == 4'd1) ? 3 : 1;
        full_opcode = make_op(sh, col, l1, l2, l3);
        for (int k = 0; k < n; k++) begin
            @(negedge tb_clk);
            check({tag, ".enable"},     64'(enable),     64'd1);
            check({tag, ".write"},      64'(write),      64'd1);
            check({tag, ".locations"},  64'(locations),  64'({pt[a[k]], pt[b[k]]}));
            check({tag, ".prim_sel"},   64'(prim_sel),   64'(sh == 4'd2));
            check({tag, ".shape_done"}, 64'(shape_done), 64'd0);
            check({tag, ".read"},       64'(read),       64'd0);
            check({tag, ".color"},      64'(color),      64'(col));
            next_cycle();
        end
        check_idle({tag, ".done"}, col, 1'b1);
        next_cycle();
    endtask

    initial begin
        logic [18:0] r1, r2, r3;
        logic [15:0] rc;
        new_shape = 0; line_done = 0; arc_done = 0; data_ready = 0;
        n_reset = 1'b0;
        full_opcode = {4'hF, 92'($urandom)};
        repeat (2) next_cycle();
        n_reset = 1'b1;
        check_idle("reset", full_opcode[91:76], 1'b0);
        next_cycle();
        full_opcode = {4'h7, 92'($urandom)};
        check_idle("unsupported", full_opcode[91:76], 1'b0);
        next_cycle();

        run_shape("line",   4'd0, 16'h000A, 19'd5, 19'd9, 19'($urandom));
        run_shape("tri",    4'd1, 16'h1234, 19'd3, 19'd7, 19'd11);
        run_shape("circle", 4'd2, 16'hBEEF, 19'd2, 19'd4, 19'($urandom));
        run_shape("maxloc", 4'd1, 16'hFFFF, 19'h7FFFF, 19'h00000, 19'h7FFFF);

        // Triangle switched to LINE in P1: P1 is invalid for LINE, so DONE follows.
        full_opcode = make_op(4'd1, 16'h5555, 19'd1, 19'd2, 19'd3);
        next_cycle();
        full_opcode = make_op(4'd0, 16'h5555, 19'd1, 19'd2, 19'd3);
        next_cycle();
        @(negedge tb_clk);
        check("switch.shape_done", 64'(shape_done), 64'd1);
        next_cycle();

        // Reset while the triangle sits in P1 aborts it back to P0 with no DONE pulse.
        r1 = 19'($urandom); r2 = 19'($urandom); r3 = 19'($urandom); rc = 16'($urandom);
        full_opcode = make_op(4'd1, rc, r1, r2, r3);
        next_cycle();
        @(negedge tb_clk);
        check("rst_p1.locations", 64'(locations), 64'({r1, r3}));
        n_reset = 1'b0;
        next_cycle();
        n_reset = 1'b1;
        run_shape("rst_p1.restart", 4'd1, rc, r1, r2, r3);

        for (int i = 0; i < 1000; i++) begin
            r1 = 19'($urandom); r2 = 19'($urandom); r3 = 19'($urandom); rc = 16'($urandom);
            run_shape("rand", 4'(i % 3), rc, r1, r2, r3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
